axis_stereo_gain: RTL and testbench

AXIS_STEREO_GAIN -- requirements
Module: axis_stereo_gain

---
 rtl/axis_stereo_gain.sv | 173 +++++++++++++++++
 tb/tb_axis_stereo_gain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stereo_gain.sv
// Stereo AXI-Stream gain stage: collects a left/right beat pair, applies a signed Q2.14 gain
// per channel with saturation, and emits the pair with registered outputs.
module axis_stereo_gain #(
  parameter int unsigned AUDIO_WIDTH_P = 24,
  parameter int unsigned GAIN_WIDTH_P  = 16
) (
  input  logic                    clk_mclk,
  input  logic                    rst_n,
  input  logic [GAIN_WIDTH_P-1:0] cr_gain_l,
  input  logic [GAIN_WIDTH_P-1:0] cr_gain_r,
  input  logic                    cr_mute,
  input  logic                    cmd_clear_clip,
  input  logic [31:0]             s_axis_data,
  input  logic                    s_axis_valid,
  output logic                    s_axis_ready,
  input  logic                    s_axis_last,
  output logic [31:0]             m_axis_data,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready,
  output logic                    m_axis_last,
  output logic [15:0]             sr_clip_count
);

  localparam int unsigned ProdW = AUDIO_WIDTH_P + GAIN_WIDTH_P;
  localparam int unsigned FracW = GAIN_WIDTH_P - 2;
  localparam int unsigned PadW  = 32 - AUDIO_WIDTH_P;

  localparam logic signed [ProdW-1:0] SatMax = {{(GAIN_WIDTH_P + 1){1'b0}},
                                                {(AUDIO_WIDTH_P - 1){1'b1}}};
  localparam logic signed [ProdW-1:0] SatMin = {{(GAIN_WIDTH_P + 1){1'b1}},
                                                {(AUDIO_WIDTH_P - 1){1'b0}}};

  typedef enum logic [2:0] {StRxL, StRxR, StCalc, StTxL, StTxR} state_e;

  state_e                   state_q, state_d;
  logic [AUDIO_WIDTH_P-1:0] left_q, left_d;
  logic [AUDIO_WIDTH_P-1:0] right_q, right_d;
  logic [AUDIO_WIDTH_P-1:0] res_r_q, res_r_d;
  logic [31:0]              m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_last_q, m_last_d;
  logic                     s_ready_q, s_ready_d;
  logic [15:0]              clip_q, clip_d;

  logic                     hs_in, hs_out;
  logic [AUDIO_WIDTH_P:0]   gain_l_res, gain_r_res;
  logic [1:0]               n_clip;
  logic [16:0]              clip_sum;
  logic                     unused_hi;

  assign unused_hi = ^s_axis_data[31:AUDIO_WIDTH_P];

  // Returns {clipped, saturated sample}; the arithmetic shift floors toward minus infinity.
  function automatic logic [AUDIO_WIDTH_P:0] apply_gain(input logic [AUDIO_WIDTH_P-1:0] smp,
                                                        input logic [GAIN_WIDTH_P-1:0]  gain);
    logic signed [ProdW-1:0] prod;
    logic [AUDIO_WIDTH_P:0]  res;
    prod = ProdW'($signed(smp)) * ProdW'($signed(gain));
    prod = prod >>> FracW;
    if (prod > SatMax) begin
      res = {1'b1, SatMax[AUDIO_WIDTH_P-1:0]};
    end else if (prod < SatMin) begin
      res = {1'b1, SatMin[AUDIO_WIDTH_P-1:0]};
    end else begin
      res = {1'b0, prod[AUDIO_WIDTH_P-1:0]};
    end
    return res;
  endfunction

  assign hs_in  = s_axis_valid & s_ready_q;
  assign hs_out = m_valid_q & m_axis_ready;

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    right_d    = right_q;
    res_r_d    = res_r_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    clip_d     = clip_q;
    n_clip     = 2'd0;
    gain_l_res = apply_gain(left_q, cr_gain_l);
    gain_r_res = apply_gain(right_q, cr_gain_r);

    unique case (state_q)
      StRxL: begin
        // A stray right beat here is consumed and dropped to realign on packet boundaries.
        if (hs_in && !s_axis_last) begin
          left_d  = s_axis_data[AUDIO_WIDTH_P-1:0];
          state_d = StRxR;
        end
      end
      StRxR: begin
        if (hs_in) begin
          if (s_axis_last) begin
            right_d = s_axis_data[AUDIO_WIDTH_P-1:0];
            state_d = StCalc;
          end else begin
            left_d  = s_axis_data[AUDIO_WIDTH_P-1:0];
          end
        end
      end
      StCalc: begin
        if (cr_mute) begin
          m_data_d = '0;
          res_r_d  = '0;
        end else begin
          m_data_d = {{PadW{1'b0}}, gain_l_res[AUDIO_WIDTH_P-1:0]};
          res_r_d  = gain_r_res[AUDIO_WIDTH_P-1:0];
          n_clip   = {1'b0, gain_l_res[AUDIO_WIDTH_P]} + {1'b0, gain_r_res[AUDIO_WIDTH_P]};
        end
        m_valid_d = 1'b1;
        m_last_d  = 1'b0;
        state_d   = StTxL;
      end
      StTxL: begin
        if (hs_out) begin
          m_data_d = {{PadW{1'b0}}, res_r_q};
          m_last_d = 1'b1;
          state_d  = StTxR;
        end
      end
      StTxR: begin
        if (hs_out) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = StRxL;
        end
      end
      default: state_d = StRxL;
    endcase

    clip_sum = {1'b0, clip_q} + {15'd0, n_clip};
    clip_d   = clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
    if (cmd_clear_clip) begin
      clip_d = '0;
    end

    s_ready_d = (state_d == StRxL) || (state_d == StRxR);
  end

  always_ff @(posedge clk_mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRxL;
      left_q    <= '0;
      right_q   <= '0;
      res_r_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      s_ready_q <= 1'b0;
      clip_q    <= '0;
    end else begin
      state_q   <= state_d;
      left_q    <= left_d;
      right_q   <= right_d;
      res_r_q   <= res_r_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      s_ready_q <= s_ready_d;
      clip_q    <= clip_d;
    end
  end

  assign s_axis_ready  = s_ready_q;
  assign m_axis_data   = m_data_q;
  assign m_axis_valid  = m_valid_q;
  assign m_axis_last   = m_last_q;
  assign sr_clip_count = clip_q;

endmodule

// File: tb/tb_axis_stereo_gain.sv
// Bench for axis_stereo_gain: directed corner packets plus randomized packets checked against
// an arithmetic reference model of the gain/saturation/clip-count rules.
module tb_axis_stereo_gain;

  logic        clk_mclk = 1'b0;
  logic        rst_n;
  logic [15:0] cr_gain_l, cr_gain_r;
  logic        cr_mute, cmd_clear_clip;
  logic [31:0] s_axis_data;
  logic        s_axis_valid, s_axis_ready, s_axis_last;
  logic [31:0] m_axis_data;
  logic        m_axis_valid, m_axis_ready, m_axis_last;
  logic [15:0] sr_clip_count;

  int n_tests = 0;
  int n_fail  = 0;
  int model_clip = 0;

  always #5 clk_mclk = ~clk_mclk;

  axis_stereo_gain dut (
    .clk_mclk       (clk_mclk),
    .rst_n          (rst_n),
    .cr_gain_l      (cr_gain_l),
    .cr_gain_r      (cr_gain_r),
    .cr_mute        (cr_mute),
    .cmd_clear_clip (cmd_clear_clip),
    .s_axis_data    (s_axis_data),
    .s_axis_valid   (s_axis_valid),
    .s_axis_ready   (s_axis_ready),
    .s_axis_last    (s_axis_last),
    .m_axis_data    (m_axis_data),
    .m_axis_valid   (m_axis_valid),
    .m_axis_ready   (m_axis_ready),
    .m_axis_last    (m_axis_last),
    .sr_clip_count  (sr_clip_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Real-valued gain, floored, then clamped to the 24-bit signed range.
  function automatic logic [23:0] ref_gain(input logic [23:0] s, input logic [15:0] g,
                                           output bit clip);
    longint p;
    p = longint'($signed(s)) * longint'($signed(g));
    p = p >>> 14;
    clip = 1'b0;
    if (p > 64'sd8388607) begin
      p = 8388607;
      clip = 1'b1;
    end else if (p < -64'sd8388608) begin
      p = -8388608;
      clip = 1'b1;
    end
    return p[23:0];
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_beat(input logic [23:0] smp, input logic last);
    int n = 0;
    s_axis_data  = {8'($urandom), smp};
    s_axis_last  = last;
    s_axis_valid = 1'b1;
    while (!s_axis_ready && n < 100) begin
      @(negedge clk_mclk);
      n++;
    end
    check("send_ready", {63'd0, s_axis_ready}, 64'd1);
    @(negedge clk_mclk);
    s_axis_valid = 1'b0;
  endtask

  task automatic recv_beat(input int stall, output logic [31:0] d, output logic l);
    int n = 0;
    logic [31:0] hd;
    logic        hl;
    while (!m_axis_valid && n < 100) begin
      @(negedge clk_mclk);
      n++;
    end
    check("recv_valid", {63'd0, m_axis_valid}, 64'd1);
    hd = m_axis_data;
    hl = m_axis_last;
    m_axis_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      cr_gain_l = 16'($urandom);
      cr_gain_r = 16'($urandom);
      cr_mute   = 1'($urandom);
      @(negedge clk_mclk);
      check("hold_valid", {63'd0, m_axis_valid}, 64'd1);
      check("hold_data", {32'd0, m_axis_data}, {32'd0, hd});
      check("hold_last", {63'd0, m_axis_last}, {63'd0, hl});
      check("hold_sready", {63'd0, s_axis_ready}, 64'd0);
    end
    d = m_axis_data;
    l = m_axis_last;
    m_axis_ready = 1'b1;
    @(negedge clk_mclk);
    m_axis_ready = 1'b0;
  endtask

  // mode: 0 plain, 1 stray last=1 beat first, 2 resync with an extra left beat,
  // 3 clear pulse during the computation cycle.
  task automatic do_packet(input logic [23:0] l, input logic [23:0] r, input logic [15:0] gl,
                           input logic [15:0] gr, input bit mt, input int mode, input int stall);
    logic [23:0] el, er;
    bit          cl, cr;
    logic [31:0] d;
    logic        lst;
    cr_gain_l = gl;
    cr_gain_r = gr;
    cr_mute   = mt;
    el = ref_gain(l, gl, cl);
    er = ref_gain(r, gr, cr);
    if (mt) begin
      el = '0;
      er = '0;
      cl = 1'b0;
      cr = 1'b0;
    end
    if (mode == 1) send_beat(24'($urandom), 1'b1);
    if (mode == 2) send_beat(24'($urandom), 1'b0);
    send_beat(l, 1'b0);
    send_beat(r, 1'b1);
    check("calc_sready", {63'd0, s_axis_ready}, 64'd0);
    check("calc_valid", {63'd0, m_axis_valid}, 64'd0);
    if (mode == 3) cmd_clear_clip = 1'b1;
    @(negedge clk_mclk);
    cmd_clear_clip = 1'b0;
    check("latency_valid", {63'd0, m_axis_valid}, 64'd1);
    model_clip = model_clip + int'(cl) + int'(cr);
    if (model_clip > 65535) model_clip = 65535;
    if (mode == 3) model_clip = 0;
    recv_beat(stall, d, lst);
    check("left_data", {32'd0, d}, {40'd0, el});
    check("left_last", {63'd0, lst}, 64'd0);
    recv_beat(stall, d, lst);
    check("right_data", {32'd0, d}, {40'd0, er});
    check("right_last", {63'd0, lst}, 64'd1);
    check("idle_valid", {63'd0, m_axis_valid}, 64'd0);
    check("idle_sready", {63'd0, s_axis_ready}, 64'd1);
    check("clip_count", {48'd0, sr_clip_count}, 64'(model_clip));
  endtask

  function automatic logic [23:0] rand_sample();
    logic [23:0] edges [4];
    edges[0] = 24'h7FFFFF;
    edges[1] = 24'h800000;
    edges[2] = 24'h000000;
    edges[3] = 24'hFFFFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return 24'($urandom);
  endfunction

  initial begin
    logic [31:0] d;
    logic        lst;
    rst_n = 1'b0;
    cr_gain_l = 16'h4000;
    cr_gain_r = 16'h4000;
    cr_mute = 1'b0;
    cmd_clear_clip = 1'b0;
    s_axis_data = '0;
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    m_axis_ready = 1'b0;
    repeat (3) @(negedge clk_mclk);
    check("rst_sready", {63'd0, s_axis_ready}, 64'd0);
    check("rst_valid", {63'd0, m_axis_valid}, 64'd0);
    check("rst_last", {63'd0, m_axis_last}, 64'd0);
    check("rst_data", {32'd0, m_axis_data}, 64'd0);
    check("rst_clip", {48'd0, sr_clip_count}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk_mclk);
    check("first_edge_sready", {63'd0, s_axis_ready}, 64'd1);

    do_packet(24'h000123, 24'hFFFFFF, 16'h4000, 16'h4000, 1'b0, 0, 0);
    check("unity_no_clip", {48'd0, sr_clip_count}, 64'd0);
    do_packet(24'h600000, 24'hA00000, 16'h6000, 16'h6000, 1'b0, 0, 1);
    check("both_clip", {48'd0, sr_clip_count}, 64'd2);
    cmd_clear_clip = 1'b1;
    @(negedge clk_mclk);
    cmd_clear_clip = 1'b0;
    model_clip = 0;
    check("clip_cleared", {48'd0, sr_clip_count}, 64'd0);
    do_packet(24'h000010, 24'h000020, 16'h4000, 16'h4000, 1'b0, 1, 0);
    do_packet(24'h000321, 24'h000654, 16'h2000, 16'hC000, 1'b0, 0, 10);
    do_packet(24'h7FFFFF, 24'h800000, 16'h7FFF, 16'h7FFF, 1'b1, 0, 4);

    // Asynchronous reset while the right beat is on the bus.
    cr_gain_l = 16'h4000;
    cr_gain_r = 16'h4000;
    cr_mute = 1'b0;
    send_beat(24'h000005, 1'b0);
    send_beat(24'h000006, 1'b1);
    recv_beat(0, d, lst);
    check("txr_last", {63'd0, m_axis_last}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, m_axis_valid}, 64'd0);
    check("midrst_sready", {63'd0, s_axis_ready}, 64'd0);
    model_clip = 0;
    @(negedge clk_mclk);
    rst_n = 1'b1;
    m_axis_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_mclk);
      check("post_rst_no_beat", {63'd0, m_axis_valid}, 64'd0);
    end
    m_axis_ready = 1'b0;
    do_packet(24'h000001, 24'h000002, 16'h4000, 16'h4000, 1'b0, 0, 0);

    for (int p = 0; p < 40; p++) begin
      logic [15:0] gl, gr;
      gl = ($urandom_range(0, 3) == 0) ? 16'h4000 : 16'($urandom);
      gr = ($urandom_range(0, 3) == 0) ? 16'h4000 : 16'($urandom);
      do_packet(rand_sample(), rand_sample(), gl, gr, ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        cmd_clear_clip = 1'b1;
        @(negedge clk_mclk);
        cmd_clear_clip = 1'b0;
        model_clip = 0;
        check("rand_clear", {48'd0, sr_clip_count}, 64'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
